uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 The block SHALL have parameter SB_TICKS, default 16, i_tick pulses per bit period (start, data and stop bits).
REQ-003 The block SHALL have port i_clock  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port i_reset  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port i_tick  input  1  baud enable, one-clock pulse at 16x baud rate.
REQ-006 The block SHALL have port i_tx_start  input  1  request to send i_data_byte.
REQ-007 The block SHALL have port i_data_byte  input  DATA_BITS  byte to transmit.
REQ-008 The block SHALL have port o_tx  output  1  serial line; idle high.
REQ-009 The block SHALL have port o_tx_busy  output  1  high while a frame is in progress.
REQ-010 The block SHALL have port o_done_bit  output  1  one-clock pulse at frame end.

Function
REQ-011 The FSM SHALL be one-hot with exactly four states: IDLE=4'b0001, START=4'b0010, DATA=4'b0100, STOP=4'b1000.
REQ-012 The block SHALL hold a 4-bit tick counter, a 3-bit data index and a DATA_BITS-wide shift register; the tick counter SHALL advance only in cycles where i_tick=1.
REQ-013 In IDLE with i_tx_start=1, the block SHALL latch i_data_byte into the shift register, clear the tick counter and data index, and enter START on the next edge.
REQ-014 i_tx_start SHALL be ignored in every state other than IDLE; i_data_byte changes after acceptance SHALL not affect the frame in progress.
REQ-015 o_tx SHALL be registered: 1 in IDLE, 0 in START, shift register bit 0 in DATA, 1 in STOP; o_tx SHALL first go low one clock after acceptance.
REQ-016 START SHALL last SB_TICKS i_tick pulses; on the pulse with tick counter = SB_TICKS-1, the block SHALL clear the tick counter and enter DATA.
REQ-017 In DATA, on the pulse with tick counter = SB_TICKS-1, the block SHALL shift right by one (LSB first) and clear the tick counter.
REQ-018 On that same pulse, the block SHALL increment the data index if it is below DATA_BITS-1, and otherwise clear it and enter STOP.
REQ-019 STOP SHALL last SB_TICKS i_tick pulses; on the final pulse the block SHALL return to IDLE and assert o_done_bit for exactly that one clock.
REQ-020 o_tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 A frame SHALL occupy exactly (DATA_BITS+2)*SB_TICKS i_tick pulses, which is 160 at the defaults.
REQ-022 A start asserted in the cycle after o_done_bit SHALL be accepted; back-to-back frames SHALL therefore be separated by one clock of idle-high o_tx.
REQ-023 If i_tick is asserted in the acceptance cycle, that pulse SHALL not be counted toward the start bit.
REQ-024 An undefined state SHALL recover to IDLE on the next edge with o_tx=1.
REQ-025 If i_tick stays low, the block SHALL hold its state, counters and o_tx indefinitely.

Reset
REQ-026 With i_reset=1 at a rising edge, the block SHALL enter IDLE.
REQ-027 Under that reset, the tick counter, data index and shift register SHALL clear to 0.
REQ-028 Under that reset, o_tx SHALL be 1, o_tx_busy 0 and o_done_bit 0 after that edge.
REQ-029 Reset SHALL take precedence over i_tx_start and i_tick.
REQ-030 Reset mid-frame SHALL abort the frame with no o_done_bit pulse.
REQ-031 After reset is released, the block SHALL accept a new i_tx_start on the first subsequent IDLE cycle.

Verification
REQ-032 The bench SHALL cover: send 8'hA5 with an i_tick pulse every 4 clocks -> o_tx shows 0, then bits 1,0,1,0,0,1,0,1, then 1, each held 16 ticks; o_done_bit pulses once after 160 ticks.
REQ-033 The bench SHALL cover: send 8'h00 then 8'hFF back-to-back, with i_tx_start held high -> both frames are correct, the second begins one clock after o_done_bit, and o_tx_busy drops for exactly one clock.
REQ-034 The bench SHALL cover: i_tx_start pulsed with 8'h3C while busy sending 8'h81 -> 8'h81 completes unchanged and 8'h3C is never sent.
REQ-035 The bench SHALL cover: i_reset asserted during data bit 3 of 8'h55 -> o_tx=1 and o_tx_busy=0 the next clock, with no o_done_bit; the next send of 8'h55 is correct.
REQ-036 The bench SHALL cover: i_tick held low for 1000 clocks mid-START -> o_tx stays 0 and the frame resumes correctly once ticks restart.
REQ-037 The bench SHALL cover: loopback into the team's 16x-oversampling receiver for 256 random bytes -> every byte is received equal to the byte sent.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, and one stop bit.
// Each bit lasts SB_TICKS i_tick pulses.
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data_byte,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_done_bit
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    localparam logic [3:0] LAST_TICK = 4'(SB_TICKS - 1);
    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

    state_t               state;
    logic [3:0]           tick_cnt;
    logic [2:0]           data_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tick_last;

    assign tick_last  = i_tick && (tick_cnt == LAST_TICK);
    assign shift_next = shift_reg >> 1;

    // o_tx is loaded with the level of the state being entered, so the line is glitch-free.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            data_idx   <= 3'd0;
            shift_reg  <= '0;
            o_tx       <= 1'b1;
            o_tx_busy  <= 1'b0;
            o_done_bit <= 1'b0;
        end else begin
            o_done_bit <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx      <= 1'b1;
                    o_tx_busy <= 1'b0;
                    if (i_tx_start) begin
                        shift_reg <= i_data_byte;
                        tick_cnt  <= 4'd0;
                        data_idx  <= 3'd0;
                        state     <= START;
                        o_tx      <= 1'b0;
                        o_tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (tick_last) begin
                        tick_cnt <= 4'd0;
                        state    <= DATA;
                        o_tx     <= shift_reg[0];
                    end else if (i_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        tick_cnt  <= 4'd0;
                        shift_reg <= shift_next;
                        if (data_idx < LAST_IDX) begin
                            data_idx <= data_idx + 3'd1;
                            o_tx     <= shift_next[0];
                        end else begin
                            data_idx <= 3'd0;
                            state    <= STOP;
                            o_tx     <= 1'b1;
                        end
                    end else if (i_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        tick_cnt   <= 4'd0;
                        state      <= IDLE;
                        o_tx_busy  <= 1'b0;
                        o_done_bit <= 1'b1;
                    end else if (i_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tick_cnt  <= 4'd0;
                    data_idx  <= 3'd0;
                    o_tx      <= 1'b1;
                    o_tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a 16x-oversampling line receiver
// and per-tick capture of the serial line.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;

    int tick_en = 1;
    int tick_period = 4;
    int tick_div = 0;

    int cyc = 0;
    int done_cnt = 0;
    int frame_ticks = 0;
    int tick_idx = 0;
    int cyc_done = 0;
    int last_fall_gap = 0;
    int low_run = 0;
    int last_low_run = 0;
    logic tx_prev = 1'b1;
    logic busy_prev = 1'b0;
    logic tx_at_done = 1'b0;
    logic tx_at_tick [0:159];

    int rx_state = 0;
    int rx_cnt = 0;
    int rx_bitn = 0;
    int frame_err = 0;
    logic [7:0] rx_shift = 8'h00;
    logic [7:0] rx_q [$];

    uart_tx_serializer #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_tick     (tick),
        .i_tx_start (start),
        .i_data_byte(data),
        .o_tx       (tx),
        .o_tx_busy  (busy),
        .o_done_bit (done)
    );

    always #5 clk = ~clk;

    // Tick generator: one pulse every tick_period clocks.
    always @(posedge clk) begin
        #1;
        if (tick_en != 0) begin
            tick_div = (tick_div >= tick_period - 1) ? 0 : tick_div + 1;
            tick = (tick_div == 0);
        end else begin
            tick = 1'b0;
        end
    end

    // Line monitor and receiver, sampled 3 ns after each rising edge.
    always @(posedge clk) begin
        #3;
        cyc++;
        if (done) begin
            done_cnt++;
            frame_ticks = tick_idx;
            cyc_done = cyc;
            tx_at_done = tx;
        end
        if (busy && tick) begin
            if (tick_idx < 160) tx_at_tick[tick_idx] = tx;
            tick_idx++;
        end else if (!busy) begin
            tick_idx = 0;
        end
        if (busy && !busy_prev) last_low_run = low_run;
        low_run = busy ? 0 : low_run + 1;
        busy_prev = busy;
        if (tx_prev && !tx) last_fall_gap = cyc - cyc_done;
        tx_prev = tx;

        if (rst) begin
            rx_state = 0;
        end else begin
            if (rx_state == 0 && tx == 1'b0) begin
                rx_state = 1;
                rx_cnt = 0;
            end
            if (rx_state != 0 && tick) begin
                rx_cnt++;
                if (rx_state == 1 && rx_cnt == 8) begin
                    rx_cnt = 0;
                    rx_bitn = 0;
                    rx_state = (tx == 1'b0) ? 2 : 0;
                end else if (rx_state == 2 && rx_cnt == 16) begin
                    rx_cnt = 0;
                    rx_shift = {tx, rx_shift[7:1]};
                    rx_bitn++;
                    if (rx_bitn == 8) rx_state = 3;
                end else if (rx_state == 3 && rx_cnt == 16) begin
                    if (tx != 1'b1) frame_err++;
                    rx_q.push_back(rx_shift);
                    rx_state = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit align_tick);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (align_tick && !tick && n < 16) begin
            @(posedge clk); #2;
            n++;
        end
        data = b;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        data = ~b;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk); #4;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    // seq[i] is the expected line level during bit period i (0 = start bit).
    task automatic check_frame(input string tag, input logic [9:0] seq);
        logic [15:0] pat;
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 16; i++) pat[i] = tx_at_tick[b * 16 + i];
            chk($sformatf("%s_bit%0d", tag, b), 32'(pat), seq[b] ? 32'hFFFF : 32'h0);
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp);
        if (rx_q.size() == 0) chk({tag, "_rx_present"}, 32'd0, 32'd1);
        else chk({tag, "_rx_byte"}, 32'(rx_q.pop_front()), 32'(exp));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hi;
        int snap;
        int n;
        logic [7:0] b;

        // Reset held with start and ticks active
        start = 1'b1;
        data = 8'hFF;
        repeat (4) @(posedge clk);
        #4;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);

        // 8'hA5, start aligned with a tick
        base = done_cnt;
        send(8'hA5, 1'b1);
        #2;
        chk("a5_tx_low_after_accept", 32'(tx), 32'd0);
        chk("a5_busy", 32'(busy), 32'd1);
        wait_done("a5", 1000);
        chk("a5_frame_ticks", 32'(frame_ticks), 32'd160);
        check_frame("a5", 10'b1101001010);
        repeat (5) @(posedge clk);
        #4;
        chk("a5_done_pulses", 32'(done_cnt - base), 32'd1);
        check_rx("a5", 8'hA5);

        // 8'h00 then 8'hFF with start held high
        @(posedge clk); #2;
        data = 8'h00;
        start = 1'b1;
        @(posedge clk); #2;
        data = 8'hFF;
        wait_done("b2b_first", 1000);
        chk("b2b_tx_high_at_done", 32'(tx_at_done), 32'd1);
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("b2b_second", 1000);
        chk("b2b_frame_ticks", 32'(frame_ticks), 32'd160);
        check_frame("b2b_ff", 10'b1111111110);
        chk("b2b_busy_low_cycles", 32'(last_low_run), 32'd1);
        chk("b2b_tx_fall_after_done", 32'(last_fall_gap), 32'd1);
        check_rx("b2b_first", 8'h00);
        check_rx("b2b_second", 8'hFF);

        // Start request while busy is ignored
        base = done_cnt;
        send(8'h81, 1'b0);
        repeat (200) @(posedge clk);
        #2;
        data = 8'h3C;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("busy_ign", 1000);
        check_frame("busy_ign_81", 10'b1100000010);
        repeat (800) @(posedge clk);
        #4;
        chk("busy_ign_done_pulses", 32'(done_cnt - base), 32'd1);
        chk("busy_ign_idle", 32'(busy), 32'd0);
        check_rx("busy_ign", 8'h81);
        chk("busy_ign_no_extra_rx", 32'(rx_q.size()), 32'd0);

        // Reset during data bit 3 of 8'h55
        base = done_cnt;
        send(8'h55, 1'b0);
        n = 0;
        while (tick_idx < 70 && n < 2000) begin
            @(posedge clk); #4;
            n++;
        end
        chk("abort_reached_bit3", 32'(tick_idx >= 70), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #2;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (100) @(posedge clk);
        #4;
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        chk("abort_no_rx", 32'(rx_q.size()), 32'd0);
        send(8'h55, 1'b0);
        wait_done("after_abort", 1000);
        check_frame("after_abort", 10'b1010101010);
        check_rx("after_abort", 8'h55);

        // Ticks stopped for 1000 clocks during the start bit
        send(8'h96, 1'b0);
        n = 0;
        while (tick_idx < 5 && n < 200) begin
            @(posedge clk); #4;
            n++;
        end
        tick_en = 0;
        @(posedge clk); #4;
        snap = tick_idx;
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #4;
            if (tx !== 1'b0) hi++;
        end
        chk("stall_tx_not_low", 32'(hi), 32'd0);
        chk("stall_tick_idx", 32'(tick_idx), 32'(snap));
        chk("stall_busy", 32'(busy), 32'd1);
        tick_en = 1;
        wait_done("stall", 1000);
        chk("stall_frame_ticks", 32'(frame_ticks), 32'd160);
        check_frame("stall", 10'b1100101100);
        check_rx("stall", 8'h96);

        // Loopback of random bytes, one tick per clock
        tick_period = 1;
        for (int k = 0; k < 256; k++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b0);
            wait_done($sformatf("loop%0d", k), 400);
            check_rx($sformatf("loop%0d", k), b);
        end
        chk("loop_frame_errors", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
